// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared text-buffer geometry, control codes, states and address packing
package vga_pkg;

  localparam int         COLS_DEF  = 70;
  localparam int         ROWS_DEF  = 30;
  localparam logic [7:0] BLANK_DEF = 8'h20;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;
  localparam logic [7:0] ASCII_CR = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CLR_LINE = 2'd1,
    ST_CLR_ALL  = 2'd2
  } state_t;

  typedef enum logic {
    CLR_MODE_LINE = 1'b0,
    CLR_MODE_ALL  = 1'b1
  } clr_mode_t;

  // Same layout the display side uses when reading the buffer.
  function automatic logic [15:0] pack_addr(input logic [4:0] row, input logic [6:0] col);
    return {4'b0000, row, col};
  endfunction

endpackage

// File: rtl/char_buf_writer_clr_sequencer.sv
// rtl/char_buf_writer_clr_sequencer.sv - one-cell-per-cycle blanking walker for a line or the whole screen
import vga_pkg::*;

module char_buf_writer_clr_sequencer #(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  clr_mode_t   i_mode,
  input  logic [4:0]  i_row,
  input  logic        i_en,
  output logic [15:0] o_addr,
  output logic        o_we,
  output logic        o_done
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  logic [4:0] r_row;
  logic [6:0] r_col;
  logic       w_col_last;
  logic       w_last;

  assign w_col_last = (r_col == LAST_COL);
  assign w_last     = w_col_last & ((i_mode == CLR_MODE_LINE) | (r_row == LAST_ROW));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row <= 5'd0;
      r_col <= 7'd0;
    end else if (i_start) begin
      r_row <= i_row;
      r_col <= 7'd0;
    end else if (i_en) begin
      if (w_col_last) begin
        r_col <= 7'd0;
        if (i_mode == CLR_MODE_ALL)
          r_row <= (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
      end else begin
        r_col <= r_col + 7'd1;
      end
    end
  end

  assign o_addr = pack_addr(r_row, r_col);
  assign o_we   = i_en;
  assign o_done = i_en & w_last;

endmodule

// File: rtl/char_buf_writer.sv
// rtl/char_buf_writer.sv - byte stream to text buffer writer with cursor and control-code handling
import vga_pkg::*;

module char_buf_writer #(
  parameter int         COLS  = COLS_DEF,
  parameter int         ROWS  = ROWS_DEF,
  parameter logic [7:0] BLANK = BLANK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] char_wr_addr,
  output logic [7:0]  char_wr_data,
  output logic        char_we,
  output logic [6:0]  cur_h,
  output logic [4:0]  cur_v,
  output logic        busy
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t      r_state;
  logic [6:0]  r_cur_h;
  logic [4:0]  r_cur_v;
  logic        r_we;
  logic [15:0] r_addr;
  logic [7:0]  r_data;

  state_t      w_state_nxt;
  logic [6:0]  w_h_nxt;
  logic [4:0]  w_v_nxt;
  logic [4:0]  w_v_adv;
  logic        w_accept;
  logic        w_printable;
  logic        w_byte_we;
  logic [15:0] w_byte_addr;
  logic [7:0]  w_byte_data;
  logic        w_seq_start;
  logic        w_seq_en;
  clr_mode_t   w_seq_mode;
  logic [15:0] w_seq_addr;
  logic        w_seq_we;
  logic        w_seq_done;

  assign in_ready    = (r_state == ST_IDLE) & ~rst;
  assign busy        = ~in_ready;
  assign w_accept    = in_valid & in_ready;
  assign w_printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
  // No scrolling: moving past the last row lands back on row 0.
  assign w_v_adv     = (r_cur_v == LAST_ROW) ? 5'd0 : r_cur_v + 5'd1;
  assign w_seq_en    = (r_state != ST_IDLE);
  assign w_seq_mode  = (r_state == ST_CLR_ALL) ? CLR_MODE_ALL : CLR_MODE_LINE;

  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_cur_h;
    w_v_nxt     = r_cur_v;
    w_byte_we   = 1'b0;
    w_byte_addr = pack_addr(r_cur_v, r_cur_h);
    w_byte_data = in_data;
    w_seq_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_printable) begin
            w_byte_we = 1'b1;
            if (r_cur_h != LAST_COL) begin
              w_h_nxt = r_cur_h + 7'd1;
            end else begin
              w_h_nxt     = 7'd0;
              w_v_nxt     = w_v_adv;
              w_state_nxt = ST_CLR_LINE;
              w_seq_start = 1'b1;
            end
          end else begin
            case (in_data)
              ASCII_LF: begin
                w_h_nxt     = 7'd0;
                w_v_nxt     = w_v_adv;
                w_state_nxt = ST_CLR_LINE;
                w_seq_start = 1'b1;
              end
              ASCII_CR: w_h_nxt = 7'd0;
              ASCII_BS: begin
                if (r_cur_h != 7'd0) begin
                  w_h_nxt     = r_cur_h - 7'd1;
                  w_byte_we   = 1'b1;
                  w_byte_addr = pack_addr(r_cur_v, r_cur_h - 7'd1);
                  w_byte_data = BLANK;
                end else if (r_cur_v != 5'd0) begin
                  w_h_nxt     = LAST_COL;
                  w_v_nxt     = r_cur_v - 5'd1;
                  w_byte_we   = 1'b1;
                  w_byte_addr = pack_addr(r_cur_v - 5'd1, LAST_COL);
                  w_byte_data = BLANK;
                end
              end
              ASCII_FF: begin
                w_h_nxt     = 7'd0;
                w_v_nxt     = 5'd0;
                w_state_nxt = ST_CLR_ALL;
                w_seq_start = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLR_LINE, ST_CLR_ALL: begin
        if (w_seq_done)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_CLR_ALL;
    endcase
  end

  char_buf_writer_clr_sequencer #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_clr_seq (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_seq_start),
    .i_mode (w_seq_mode),
    .i_row  (w_v_nxt),
    .i_en   (w_seq_en),
    .o_addr (w_seq_addr),
    .o_we   (w_seq_we),
    .o_done (w_seq_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLR_ALL;
      r_cur_h <= 7'd0;
      r_cur_v <= 5'd0;
      r_we    <= 1'b0;
      r_addr  <= 16'd0;
      r_data  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cur_h <= w_h_nxt;
      r_cur_v <= w_v_nxt;
      r_we    <= w_seq_we | w_byte_we;
      if (w_seq_we) begin
        r_addr <= w_seq_addr;
        r_data <= BLANK;
      end else if (w_byte_we) begin
        r_addr <= w_byte_addr;
        r_data <= w_byte_data;
      end
    end
  end

  assign char_we      = r_we;
  assign char_wr_addr = r_addr;
  assign char_wr_data = r_data;
  assign cur_h        = r_cur_h;
  assign cur_v        = r_cur_v;

endmodule
